// File: rtl/data_checker_pkg.sv
// Shared types and helpers for the PRBS byte checker.
// Holds the checker FSM encoding and the Galois LFSR step.
package data_checker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        CHECK,
        DONE
    } chk_state_t;

    localparam logic [7:0] DEF_POLY     = 8'hB8;
    localparam int         DEF_REPEAT_N = 10;
    localparam int         DEF_LOSS_N   = 4;

    function automatic logic [7:0] lfsr_step(
        input logic [7:0] x,
        input logic [7:0] poly
    );
        return (x >> 1) ^ (x[0] ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/data_checker_sv_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; the count sticks at all-ones.
module sat_counter_sv #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // next count: clear, saturating increment or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/data_checker_sv.sv
// Receive-side PRBS checker: locks onto an 8-bit Galois
// LFSR stream and counts checked and mismatched words.
module data_checker_sv
    import data_checker_pkg::*;
#(
    parameter int         DW       = 8,
    parameter logic [7:0] POLY     = DEF_POLY,
    parameter int         REPEAT_N = DEF_REPEAT_N,
    parameter int         LOSS_N   = DEF_LOSS_N,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DW-1:0]    d_in,
    input  logic             d_vld,
    output logic             d_rdy,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] word_cnt,
    output logic             done
);

    localparam int MR_W = $clog2(LOSS_N + 1);

    chk_state_t      state_q, state_d;
    logic [DW-1:0]   exp_q, exp_d;
    logic [MR_W-1:0] miss_run_q, miss_run_d;
    logic            locked_q, locked_d;
    logic            err_q, err_d;
    logic            done_q, done_d;

    logic cnt_clr;
    logic word_inc;
    logic err_inc;
    logic xfer;
    logic mismatch;
    logic word_last;
    logic miss_last;

    assign d_rdy     = (state_q == SYNC) || (state_q == CHECK);
    assign xfer      = d_vld && d_rdy;
    assign mismatch  = (d_in != exp_q);
    assign word_last = (word_cnt == CNT_W'(REPEAT_N - 1));
    assign miss_last = mismatch
                    && (miss_run_q == MR_W'(LOSS_N - 1));

    // next-state, expected word and run-length logic
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        miss_run_d = miss_run_q;
        locked_d   = locked_q;
        done_d     = done_q;
        err_d      = 1'b0;
        cnt_clr    = 1'b0;
        word_inc   = 1'b0;
        err_inc    = 1'b0;
        if (!en) begin
            state_d  = IDLE;
            locked_d = 1'b0;
            done_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d    = SYNC;
                    cnt_clr    = 1'b1;
                    miss_run_d = '0;
                end
                SYNC: begin
                    // zero is the LFSR lock-up value, never a seed
                    if (xfer && (d_in != '0)) begin
                        exp_d    = lfsr_step(d_in, POLY);
                        state_d  = CHECK;
                        locked_d = 1'b1;
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        word_inc = 1'b1;
                        exp_d    = lfsr_step(exp_q, POLY);
                        if (mismatch) begin
                            err_d      = 1'b1;
                            err_inc    = 1'b1;
                            miss_run_d = miss_run_q + 1'b1;
                        end else begin
                            miss_run_d = '0;
                        end
                        if (word_last) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else if (miss_last) begin
                            state_d    = SYNC;
                            locked_d   = 1'b0;
                            miss_run_d = '0;
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // FSM and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            exp_q      <= '0;
            miss_run_q <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            miss_run_q <= miss_run_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    sat_counter_sv #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (err_inc),
        .cnt (err_cnt)
    );

    sat_counter_sv #(
        .CNT_W (CNT_W)
    ) u_word_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (word_inc),
        .cnt (word_cnt)
    );

    assign locked = locked_q;
    assign err    = err_q;
    assign done   = done_q;

endmodule

// File: tb/tb_data_checker_sv.sv
// Directed bench for data_checker_sv with a per-cycle
// reference model feeding an expected-result queue.
module tb_data_checker_sv;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  d_in;
    logic        d_vld;
    logic        d_rdy;
    logic        locked;
    logic        err;
    logic        done;
    logic [15:0] err_cnt;
    logic [15:0] word_cnt;

    always #5 clk = ~clk;

    data_checker_sv dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .d_in     (d_in),
        .d_vld    (d_vld),
        .d_rdy    (d_rdy),
        .locked   (locked),
        .err      (err),
        .err_cnt  (err_cnt),
        .word_cnt (word_cnt),
        .done     (done)
    );

    typedef struct packed {
        logic        locked;
        logic        err;
        logic        done;
        logic [15:0] ec;
        logic [15:0] wc;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // reference model state: 0 IDLE, 1 SYNC, 2 CHECK, 3 DONE
    int          ms     = 0;
    logic [7:0]  mexp   = 8'h00;
    int          mmiss  = 0;
    logic        mlock  = 1'b0;
    logic        mdone  = 1'b0;
    logic        merr   = 1'b0;
    logic [15:0] mec    = 16'h0;
    logic [15:0] mwc    = 16'h0;
    logic        mvalid = 1'b0;
    logic [7:0]  cur;

    function automatic logic [7:0] nxt(input logic [7:0] x);
        if (x[0]) return (x >> 1) ^ 8'hB8;
        return x >> 1;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h",
                   tag, got, want);
        end
    endtask

    task automatic model(input logic e, input logic r,
                         input logic v, input logic [7:0] b);
        if (r) begin
            ms = 0; mexp = 0; mmiss = 0; mlock = 0;
            mdone = 0; merr = 0; mec = 0; mwc = 0;
        end else if (!e) begin
            ms = 0; mlock = 0; mdone = 0; merr = 0;
        end else begin
            merr = 0;
            case (ms)
                0: begin
                    ms = 1; mec = 0; mwc = 0; mmiss = 0;
                end
                1: if (v && b != 8'h00) begin
                    mexp = nxt(b); ms = 2; mlock = 1;
                end
                2: if (v) begin
                    mwc++;
                    if (b !== mexp) begin
                        merr = 1; mec++; mmiss++;
                    end else begin
                        mmiss = 0;
                    end
                    mexp = nxt(mexp);
                    if (mwc == 16'd10) begin
                        ms = 3; mdone = 1;
                    end else if (mmiss == 4) begin
                        ms = 1; mlock = 0; mmiss = 0;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input logic e, input logic r,
                       input logic v, input logic [7:0] b);
        exp_t x;
        @(negedge clk);
        en = e; rst = r; d_vld = v; d_in = b;
        #1;
        if (mvalid)
            chk("d_rdy", {31'b0, d_rdy},
                {31'b0, (ms == 1 || ms == 2)});
        model(e, r, v, b);
        mvalid = 1'b1;
        x.locked = mlock;
        x.err    = merr;
        x.done   = mdone;
        x.ec     = mec;
        x.wc     = mwc;
        sbq.push_back(x);
        @(posedge clk);
        #1;
        x = sbq.pop_front();
        chk("locked", {31'b0, locked}, {31'b0, x.locked});
        chk("err", {31'b0, err}, {31'b0, x.err});
        chk("done", {31'b0, done}, {31'b0, x.done});
        chk("err_cnt", {16'b0, err_cnt}, {16'b0, x.ec});
        chk("word_cnt", {16'b0, word_cnt}, {16'b0, x.wc});
    endtask

    task automatic send(input logic [7:0] b);
        cyc(1'b1, 1'b0, 1'b1, b);
    endtask

    task automatic restart();
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int k;
        rst = 1'b1; en = 1'b0; d_vld = 1'b0; d_in = 8'h00;

        // reset state
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        chk("rst_rdy", {31'b0, d_rdy}, 32'd0);
        chk("rst_lock", {31'b0, locked}, 32'd0);
        chk("rst_wc", {16'b0, word_cnt}, 32'd0);

        // 1: clean stream
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cur = 8'h01;
        send(cur);
        chk("t1_lock", {31'b0, locked}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            cur = nxt(cur);
            send(cur);
        end
        chk("t1_done", {31'b0, done}, 32'd1);
        chk("t1_rdy", {31'b0, d_rdy}, 32'd0);
        chk("t1_ec", {16'b0, err_cnt}, 32'd0);
        chk("t1_wc", {16'b0, word_cnt}, 32'd10);
        send(8'h55);
        chk("t1_hold", {16'b0, word_cnt}, 32'd10);

        // 6B: en low in DONE, counts held until restart
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t6b_done", {31'b0, done}, 32'd0);
        chk("t6b_wc", {16'b0, word_cnt}, 32'd10);
        cyc(1'b0, 1'b0, 1'b1, 8'h01);
        chk("t6b_wc2", {16'b0, word_cnt}, 32'd10);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("t6b_clr", {16'b0, word_cnt}, 32'd0);
        chk("t6b_rdy", {31'b0, d_rdy}, 32'd1);

        // 2: single error on 3rd checked word
        cur = 8'h01;
        send(cur);
        for (int i = 0; i < 10; i++) begin
            cur = nxt(cur);
            send(i == 2 ? 8'h00 : cur);
            if (i == 2) begin
                chk("t2_err", {31'b0, err}, 32'd1);
                chk("t2_lock", {31'b0, locked}, 32'd1);
            end
        end
        chk("t2_ec", {16'b0, err_cnt}, 32'd1);
        chk("t2_done", {31'b0, done}, 32'd1);

        // 3: lock loss and relock
        restart();
        cur = 8'h01;
        send(cur);
        cur = nxt(cur); send(cur);
        cur = nxt(cur); send(cur);
        for (int i = 0; i < 4; i++) send(8'hFF);
        chk("t3_ec", {16'b0, err_cnt}, 32'd4);
        chk("t3_lock", {31'b0, locked}, 32'd0);
        chk("t3_rdy", {31'b0, d_rdy}, 32'd1);
        cur = 8'h17;
        send(cur);
        for (int i = 0; i < 3; i++) begin
            cur = nxt(cur);
            send(cur);
        end
        chk("t3_relock", {31'b0, locked}, 32'd1);
        chk("t3_ec2", {16'b0, err_cnt}, 32'd4);
        chk("t3_wc", {16'b0, word_cnt}, 32'd9);

        // 4: zero sync words ignored
        restart();
        send(8'h00);
        send(8'h00);
        chk("t4_nolock", {31'b0, locked}, 32'd0);
        cur = 8'h01;
        send(cur);
        cur = nxt(cur);
        send(cur);
        chk("t4_wc", {16'b0, word_cnt}, 32'd1);
        chk("t4_ec", {16'b0, err_cnt}, 32'd0);
        chk("t4_lock", {31'b0, locked}, 32'd1);

        // 5: handshake gaps with junk data
        k = 1;
        for (int it = 0; it < 200 && k < 10; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                cur = nxt(cur);
                send(cur);
                k++;
            end else begin
                cyc(1'b1, 1'b0, 1'b0,
                    8'($urandom_range(0, 255)));
            end
        end
        chk("t5_done", {31'b0, done}, 32'd1);
        chk("t5_ec", {16'b0, err_cnt}, 32'd0);
        chk("t5_wc", {16'b0, word_cnt}, 32'd10);

        // 6A: reset mid-CHECK with a transfer pending
        restart();
        cur = 8'h01;
        send(cur);
        cur = nxt(cur); send(cur);
        cur = nxt(cur); send(8'h00);
        cyc(1'b1, 1'b1, 1'b1, nxt(cur));
        chk("t6a_lock", {31'b0, locked}, 32'd0);
        chk("t6a_err", {31'b0, err}, 32'd0);
        chk("t6a_ec", {16'b0, err_cnt}, 32'd0);
        chk("t6a_wc", {16'b0, word_cnt}, 32'd0);
        chk("t6a_rdy", {31'b0, d_rdy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
